// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Next-PC and fetch-control sequencer for the 5-stage pipeline. Each cycle it
// picks the value the PC register loads and whether the PC holds. The choice
// depends on the current PC, load-use stalls, EX-stage redirects and
// halt/resume control. It also drives the IF/ID flush/hold and ID/EX bubble
// controls, sequences RUN/FLUSH/HALT, and keeps saturating stall and redirect
// counters.
//
// Parameters
//   FLUSH_CYCLES    cycles IF/ID is flushed after a redirect (1..3)
//   RESET_VECTOR    pc_next value while reset is high
//
// Ports
//   clk              single clock, rising-edge
//   reset            synchronous, active-high
//   pc_cur           current PC register output
//   stall_req        load-use hazard from ID (level)
//   redirect_valid   taken branch / resolved jump from EX
//   redirect_target  redirect address, valid with redirect_valid
//   halt_req         enter HALT
//   resume           leave HALT (single-cycle pulse)
//   pc_next          value for the PC register input
//   pc_hold          1 = PC keeps its value
//   if_id_flush      clear IF/ID to NOP
//   if_id_hold       freeze IF/ID
//   id_ex_bubble     insert NOP into ID/EX
//   halted           high while in HALT
//   misalign_err     sticky misaligned-redirect flag
//   stall_count      saturating count of stall cycles
//   redirect_count   saturating count of accepted redirects

module pc_sequencer #(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        stall_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc_next,
  output logic        pc_hold,
  output logic        if_id_flush,
  output logic        if_id_hold,
  output logic        id_ex_bubble,
  output logic        halted,
  output logic        misalign_err,
  output logic [15:0] stall_count,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Value loaded into fcnt on an accepted redirect: the number of FLUSH
  // cycles still to come after the redirect cycle itself.
  localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  fcnt;
  logic [1:0]  fcnt_nxt;

  logic        active;
  logic        accept_halt;
  logic        redirect_hit;
  logic        misaligned;
  logic        take_redirect;
  logic        take_stall;
  logic [31:0] pc_seq;

  // Event decode. HALT ignores every request except resume.
  // In RUN and FLUSH, halt_req outranks redirects, and redirects outrank
  // stalls. A stall only counts in RUN: in FLUSH the ID instruction is
  // already being flushed.
  assign active        = (state != ST_HALT);
  assign accept_halt   = active & halt_req;
  assign redirect_hit  = active & ~halt_req & redirect_valid;
  assign misaligned    = redirect_hit & (redirect_target[1:0] != 2'b00);
  assign take_redirect = redirect_hit & ~misaligned;
  assign take_stall    = (state == ST_RUN) & ~halt_req & ~redirect_valid & stall_req;

  // Sequential fetch address; the 32-bit add wraps FFFF_FFFC to 0.
  assign pc_seq = pc_cur + 32'd4;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      fcnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      ST_RUN, ST_FLUSH: begin
        if (accept_halt || misaligned) begin
          state_nxt = ST_HALT;
          fcnt_nxt  = 2'd0;
        end else if (take_redirect) begin
          // A redirect arriving in FLUSH restarts the flush window.
          if (FLUSH_CYCLES > 1) begin
            state_nxt = ST_FLUSH;
            fcnt_nxt  = FCNT_INIT;
          end else begin
            state_nxt = ST_RUN;
            fcnt_nxt  = 2'd0;
          end
        end else if (state == ST_FLUSH) begin
          // fcnt <= 1 is the last flush cycle; the 0 case guards against
          // ever getting stuck in FLUSH.
          if (fcnt <= 2'd1) begin
            state_nxt = ST_RUN;
            fcnt_nxt  = 2'd0;
          end else begin
            fcnt_nxt = fcnt - 2'd1;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_nxt = ST_RUN;
          fcnt_nxt  = 2'd0;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        fcnt_nxt  = 2'd0;
      end
    endcase
  end

  // Output logic. Every output is combinational from the inputs and the
  // state. Reset overrides everything in the same cycle, so a reset that
  // arrives in FLUSH or HALT takes effect immediately.
  always_comb begin
    pc_next      = pc_seq;
    pc_hold      = 1'b0;
    if_id_flush  = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    if (reset) begin
      pc_next = RESET_VECTOR;
    end else begin
      case (state)
        ST_RUN, ST_FLUSH: begin
          if (accept_halt || misaligned) begin
            pc_hold     = 1'b1;
            if_id_flush = 1'b1;
          end else if (take_redirect) begin
            pc_next      = redirect_target;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (state == ST_FLUSH) begin
            if_id_flush = 1'b1;
          end else if (take_stall) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        ST_HALT: begin
          pc_hold     = 1'b1;
          if_id_flush = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          pc_next = pc_seq;
        end
      endcase
    end
  end

  // Performance counters and the sticky misalignment flag. Counters
  // saturate at FFFF instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count    <= 16'd0;
      redirect_count <= 16'd0;
      misalign_err   <= 1'b0;
    end else begin
      if (take_stall && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (take_redirect && (redirect_count != 16'hFFFF)) begin
        redirect_count <= redirect_count + 16'd1;
      end
      if (misaligned) begin
        misalign_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer (FLUSH_CYCLES = 2, RESET_VECTOR =
// 0x1000). A hand-written table of {inputs, expected outputs} walks the
// directed scenarios. A randomized phase follows, checked against an
// event-level reference model. The model tracks "halted", "flush cycles
// left", the counters and the PC the pipeline would hold.

module tb_pc_sequencer;

  localparam int          FC = 2;
  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic [31:0] pc_cur;
  logic        stall_req;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc_next;
  logic        pc_hold;
  logic        if_id_flush;
  logic        if_id_hold;
  logic        id_ex_bubble;
  logic        halted;
  logic        misalign_err;
  logic [15:0] stall_count;
  logic [15:0] redirect_count;

  pc_sequencer #(
    .FLUSH_CYCLES (FC),
    .RESET_VECTOR (RV)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_cur          (pc_cur),
    .stall_req       (stall_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_next         (pc_next),
    .pc_hold         (pc_hold),
    .if_id_flush     (if_id_flush),
    .if_id_hold      (if_id_hold),
    .id_ex_bubble    (id_ex_bubble),
    .halted          (halted),
    .misalign_err    (misalign_err),
    .stall_count     (stall_count),
    .redirect_count  (redirect_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
  } in_t;

  typedef struct {
    logic        chk_next;
    logic [31:0] next;
    logic        hold;
    logic        flush;
    logic        ifhold;
    logic        bubble;
    logic        halted;
    logic [15:0] st;
    logic [15:0] rd;
    logic        mis;
  } exp_t;

  typedef struct {
    in_t  in;
    exp_t ex;
  } vec_t;

  vec_t table_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  bit          m_halted;
  int          m_flush_left;
  int          m_stalls;
  int          m_redirs;
  bit          m_mis;
  logic [31:0] m_pc;

  task automatic add_row(input logic rst, input logic stall, input logic rv,
                         input logic [31:0] rt, input logic halt, input logic res,
                         input logic [31:0] pc, input logic chk_next,
                         input logic [31:0] next, input logic hold,
                         input logic flush, input logic ifhold, input logic bubble,
                         input logic hlt, input logic [15:0] st,
                         input logic [15:0] rd, input logic mis);
    vec_t r;
    r.in.rst = rst;  r.in.stall = stall; r.in.rv = rv; r.in.rt = rt;
    r.in.halt = halt; r.in.resume = res; r.in.pc = pc;
    r.ex.chk_next = chk_next; r.ex.next = next; r.ex.hold = hold;
    r.ex.flush = flush; r.ex.ifhold = ifhold; r.ex.bubble = bubble;
    r.ex.halted = hlt; r.ex.st = st; r.ex.rd = rd; r.ex.mis = mis;
    table_q.push_back(r);
  endtask

  task automatic applyStimulus(input in_t v);
    reset           = v.rst;
    stall_req       = v.stall;
    redirect_valid  = v.rv;
    redirect_target = v.rt;
    halt_req        = v.halt;
    resume          = v.resume;
    pc_cur          = v.pc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    if (e.chk_next) checkOutput({tag, " pc_next"}, pc_next, e.next);
    checkOutput({tag, " pc_hold"},        32'(pc_hold),        32'(e.hold));
    checkOutput({tag, " if_id_flush"},    32'(if_id_flush),    32'(e.flush));
    checkOutput({tag, " if_id_hold"},     32'(if_id_hold),     32'(e.ifhold));
    checkOutput({tag, " id_ex_bubble"},   32'(id_ex_bubble),   32'(e.bubble));
    checkOutput({tag, " halted"},         32'(halted),         32'(e.halted));
    checkOutput({tag, " stall_count"},    32'(stall_count),    32'(e.st));
    checkOutput({tag, " redirect_count"}, 32'(redirect_count), 32'(e.rd));
    checkOutput({tag, " misalign_err"},   32'(misalign_err),   32'(e.mis));
  endtask

  // Expected outputs for this cycle, from the event rules and model state.
  function automatic exp_t model_eval(input in_t v);
    exp_t e;
    e.chk_next = 1'b1;
    e.next     = v.pc + 32'd4;
    e.hold     = 1'b0;
    e.flush    = 1'b0;
    e.ifhold   = 1'b0;
    e.bubble   = 1'b0;
    e.halted   = m_halted && !v.rst;
    e.st       = 16'(m_stalls);
    e.rd       = 16'(m_redirs);
    e.mis      = m_mis;
    if (v.rst) begin
      e.next = RV;
    end else if (m_halted || v.halt || (v.rv && v.rt[1:0] != 2'b00)) begin
      e.hold = 1'b1; e.flush = 1'b1; e.chk_next = 1'b0;
    end else if (v.rv) begin
      e.next = v.rt; e.flush = 1'b1; e.bubble = 1'b1;
    end else if (m_flush_left > 0) begin
      e.flush = 1'b1;
    end else if (v.stall) begin
      e.hold = 1'b1; e.ifhold = 1'b1; e.bubble = 1'b1; e.chk_next = 1'b0;
    end
    return e;
  endfunction

  // Model state change at the clock edge.
  task automatic model_advance(input in_t v);
    if (v.rst) begin
      m_halted = 0; m_flush_left = 0; m_stalls = 0; m_redirs = 0; m_mis = 0;
    end else if (m_halted) begin
      if (v.resume) m_halted = 0;
    end else if (v.halt) begin
      m_halted = 1; m_flush_left = 0;
    end else if (v.rv && v.rt[1:0] != 2'b00) begin
      m_mis = 1; m_halted = 1; m_flush_left = 0;
    end else if (v.rv) begin
      if (m_redirs < 65535) m_redirs++;
      m_flush_left = FC - 1;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (v.stall) begin
      if (m_stalls < 65535) m_stalls++;
    end
  endtask

  task automatic run_cycle(input in_t v, input exp_t e, input string tag);
    applyStimulus(v);
    #4;
    check_all(tag, e);
    @(posedge clk);
    model_advance(v);
    #1;
  endtask

  initial begin
    in_t  v;
    exp_t e;

    // Table columns: rst stall rv rt halt resume pc | chk next hold flush ifhold bubble halted st rd mis
    // Sequential fetch, including the wrap at the top of the address space.
    add_row(1,0,0,32'h0,0,0,32'h1234,     1,RV,          0,0,0,0,0, 0,0,0);
    add_row(1,0,0,32'h0,0,0,32'h1234,     1,RV,          0,0,0,0,0, 0,0,0);
    add_row(0,0,0,32'h0,0,0,32'h0,        1,32'h4,       0,0,0,0,0, 0,0,0);
    add_row(0,0,0,32'h0,0,0,32'h4,        1,32'h8,       0,0,0,0,0, 0,0,0);
    add_row(0,0,0,32'h0,0,0,32'h8,        1,32'hC,       0,0,0,0,0, 0,0,0);
    add_row(0,0,0,32'h0,0,0,32'hFFFF_FFFC,1,32'h0,       0,0,0,0,0, 0,0,0);
    // Three-cycle stall at 0x40.
    add_row(0,1,0,32'h0,0,0,32'h40,       0,32'h0,       1,0,1,1,0, 0,0,0);
    add_row(0,1,0,32'h0,0,0,32'h40,       0,32'h0,       1,0,1,1,0, 1,0,0);
    add_row(0,1,0,32'h0,0,0,32'h40,       0,32'h0,       1,0,1,1,0, 2,0,0);
    add_row(0,0,0,32'h0,0,0,32'h40,       1,32'h44,      0,0,0,0,0, 3,0,0);
    // Redirect to 0x100, one FLUSH cycle with an ignored stall, then RUN.
    add_row(0,0,1,32'h100,0,0,32'h20,     1,32'h100,     0,1,0,1,0, 3,0,0);
    add_row(0,1,0,32'h0,0,0,32'h100,      1,32'h104,     0,1,0,0,0, 3,1,0);
    add_row(0,0,0,32'h0,0,0,32'h104,      1,32'h108,     0,0,0,0,0, 3,1,0);
    // halt + redirect + stall together, requests ignored in HALT, resume + halt.
    add_row(0,1,1,32'h200,1,0,32'h108,    0,32'h0,       1,1,0,0,0, 3,1,0);
    add_row(0,1,1,32'h300,1,0,32'h108,    0,32'h0,       1,1,0,0,1, 3,1,0);
    add_row(0,0,0,32'h0,1,1,32'h108,      0,32'h0,       1,1,0,0,1, 3,1,0);
    add_row(0,0,0,32'h0,0,0,32'h108,      1,32'h10C,     0,0,0,0,0, 3,1,0);
    // Misaligned redirect: sticky error, HALT, resume keeps the error.
    add_row(0,0,1,32'h102,0,0,32'h10C,    0,32'h0,       1,1,0,0,0, 3,1,0);
    add_row(0,0,0,32'h0,0,0,32'h10C,      0,32'h0,       1,1,0,0,1, 3,1,1);
    add_row(0,0,0,32'h0,0,1,32'h10C,      0,32'h0,       1,1,0,0,1, 3,1,1);
    add_row(0,0,0,32'h0,0,0,32'h110,      1,32'h114,     0,0,0,0,0, 3,1,1);
    // Reset while in HALT.
    add_row(0,0,0,32'h0,1,0,32'h110,      0,32'h0,       1,1,0,0,0, 3,1,1);
    add_row(1,0,0,32'h0,0,0,32'h110,      1,RV,          0,0,0,0,0, 3,1,1);
    add_row(0,0,0,32'h0,0,0,32'h1000,     1,32'h1004,    0,0,0,0,0, 0,0,0);
    // Reset while in FLUSH; the next cycle is RUN (stall honoured).
    add_row(0,0,1,32'h200,0,0,32'h1004,   1,32'h200,     0,1,0,1,0, 0,0,0);
    add_row(1,0,0,32'h0,0,0,32'h200,      1,RV,          0,0,0,0,0, 0,1,0);
    add_row(0,1,0,32'h0,0,0,32'h1000,     0,32'h0,       1,0,1,1,0, 0,0,0);
    // Redirect in FLUSH restarts the flush window; resume in RUN is a no-op.
    add_row(0,0,1,32'h300,0,0,32'h1000,   1,32'h300,     0,1,0,1,0, 1,0,0);
    add_row(0,0,1,32'h400,0,0,32'h300,    1,32'h400,     0,1,0,1,0, 1,1,0);
    add_row(0,0,0,32'h0,0,0,32'h400,      1,32'h404,     0,1,0,0,0, 1,2,0);
    add_row(0,0,0,32'h0,0,1,32'h404,      1,32'h408,     0,0,0,0,0, 1,2,0);

    // Initial reset so registered outputs are defined.
    v = '{rst:1'b1, stall:1'b0, rv:1'b0, rt:32'h0, halt:1'b0, resume:1'b0, pc:32'h0};
    applyStimulus(v);
    repeat (2) @(posedge clk);
    model_advance(v);
    m_pc = RV;
    #1;

    foreach (table_q[i]) begin
      run_cycle(table_q[i].in, table_q[i].ex, $sformatf("row%0d", i));
    end

    // Randomized phase against the reference model.
    m_pc = 32'h408;
    for (int n = 0; n < 400; n++) begin
      v.rst   = ($urandom_range(0, 49) == 0);
      v.stall = ($urandom_range(0, 2) == 0);
      v.rv    = ($urandom_range(0, 3) == 0);
      v.rt    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) v.rt[1:0] = 2'($urandom_range(1, 3));
      v.halt   = ($urandom_range(0, 9) == 0);
      v.resume = m_halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 29) == 0) m_pc = 32'hFFFF_FFFC;
      v.pc = m_pc;
      e = model_eval(v);
      run_cycle(v, e, $sformatf("rnd%0d", n));
      if (v.rst || !e.hold) m_pc = e.next;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC and fetch-control sequencer for the 5-stage pipeline. Each cycle it computes the value loaded into the PC register and the PC's hold control from the current PC, load-use stall requests, EX-stage redirects and halt/resume control. It also generates the IF/ID and ID/EX flush/bubble controls. It owns the RUN/FLUSH/HALT sequencing and the stall/redirect performance counters.

## Interface
- FLUSH_CYCLES, 1, cycles for which IF/ID is flushed after a redirect; legal range 1..3
- RESET_VECTOR, 32'h0000_0000, pc_next value driven while reset is high
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- pc_cur  input  32  current PC register output
- stall_req  input  1  load-use hazard from ID; level-sensitive
- redirect_valid  input  1  branch taken or jump resolved in EX
- redirect_target  input  32  target address, valid with redirect_valid
- halt_req  input  1  enter HALT (ecall/ebreak/debug)
- resume  input  1  leave HALT; single-cycle pulse
- pc_next  output  32  value for the PC register's PC_in
- pc_hold  output  1  to the PC register's PCWrite; 1 = PC keeps its value
- if_id_flush  output  1  clear IF/ID to NOP
- if_id_hold  output  1  freeze IF/ID
- id_ex_bubble  output  1  insert NOP into ID/EX
- halted  output  1  high while in HALT
- misalign_err  output  1  sticky; set by a misaligned redirect, cleared only by reset
- stall_count  output  16  saturating count of stall cycles
- redirect_count  output  16  saturating count of accepted redirects

## Operation
- **States:** RUN, FLUSH, HALT. The state register and a 2-bit flush counter `fcnt` are registered.
- **Default in RUN and FLUSH:** pc_next = pc_cur + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0. pc_hold = 0. All flush, hold and bubble outputs = 0.
- **Priority in RUN:** halt_req, then redirect_valid, then stall_req.
- **halt_req in RUN or FLUSH:**
  - pc_hold = 1, if_id_flush = 1.
  - Next state HALT.
  - A coincident redirect or stall is discarded.
- **redirect_valid in RUN or FLUSH, target[1:0] == 0:**
  - pc_next = redirect_target, if_id_flush = 1, id_ex_bubble = 1.
  - redirect_count increments.
  - If FLUSH_CYCLES > 1: next state FLUSH with fcnt = FLUSH_CYCLES-1. Otherwise next state RUN.
  - A redirect arriving in FLUSH restarts fcnt.
- **redirect_valid, target[1:0] != 0:**
  - misalign_err is set, pc_hold = 1, if_id_flush = 1.
  - Next state HALT.
  - redirect_count is not incremented.
- **stall_req in RUN, no redirect/halt:**
  - pc_hold = 1, if_id_hold = 1, id_ex_bubble = 1.
  - stall_count increments.
  - State stays RUN.
- **FLUSH:**
  - if_id_flush = 1 and PC advances by 4.
  - stall_req is ignored, since the instruction in ID is already flushed; stall_count does not increment.
  - fcnt decrements. When fcnt == 1 the next state is RUN.
- **HALT:**
  - pc_hold = 1, halted = 1, if_id_flush = 1.
  - stall_req, redirect_valid and halt_req are ignored.
  - resume moves the state to RUN on the next edge. resume wins over a coincident halt_req.
  - resume outside HALT has no effect.
- **Counters:** stick at 16'hFFFF.

## Timing
- pc_next, pc_hold and the flush/hold/bubble outputs are combinational from the inputs and state, within the same cycle. The PC register captures them at the next edge.
- A redirect in cycle N means the target is in the PC after edge N+1, i.e. a 1-edge redirect penalty plus (FLUSH_CYCLES-1) flush cycles.
- A stall held for k cycles freezes the PC for exactly k edges and adds k to stall_count.
- halted rises the cycle after halt_req and falls the cycle after resume.
- **While reset = 1:**
  - pc_next = RESET_VECTOR, pc_hold = 0.
  - if_id_flush = if_id_hold = id_ex_bubble = 0, halted = 0.
  - On the edge: state = RUN, fcnt = 0, counters = 0, misalign_err = 0.
- Reset asserted in FLUSH or HALT takes effect the same cycle. The first post-reset cycle is RUN.

## Test plan
- **Sequential fetch:** reset, then release with pc_cur 0, 4, 8 -> pc_next = 4, 8, 12; pc_hold = 0. With pc_cur = 32'hFFFF_FFFC -> pc_next = 0.
- **Stall:** stall_req high 3 cycles at pc_cur = 0x40 -> pc_hold = if_id_hold = id_ex_bubble = 1 for 3 cycles; stall_count = 3; pc_next = 0x44 afterwards.
- **Redirect, FLUSH_CYCLES = 2:** redirect 0x100 at pc_cur = 0x20 -> pc_next = 0x100 and flush that cycle; one FLUSH cycle with pc_next = 0x104; redirect_count = 1. A stall_req in the FLUSH cycle is ignored. Then RUN.
- **Simultaneous events:** halt_req + redirect + stall in one cycle -> HALT, redirect_count unchanged. resume + halt_req in HALT -> RUN next cycle.
- **Misaligned:** redirect_target = 0x102 -> misalign_err = 1 sticky, HALT, pc_hold = 1. resume -> RUN with misalign_err still 1.
- **Reset mid-operation:** reset asserted during HALT and during FLUSH -> same-cycle pc_next = RESET_VECTOR; counters, misalign_err and halted = 0 after the edge.
